// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU op codes, MIPS opcode/funct constants and control width
package alu_pkg;

   localparam int CTRL_W = 5;

   // ALU op codes, shared with the ALU itself
   localparam logic [CTRL_W-1:0] ALU_NONE = 5'b00000;
   localparam logic [CTRL_W-1:0] ALU_ADD  = 5'b00001;
   localparam logic [CTRL_W-1:0] ALU_SUB  = 5'b00010;
   localparam logic [CTRL_W-1:0] ALU_MUL  = 5'b00011;
   localparam logic [CTRL_W-1:0] ALU_SLL  = 5'b00100;
   localparam logic [CTRL_W-1:0] ALU_SRL  = 5'b00101;
   localparam logic [CTRL_W-1:0] ALU_AND  = 5'b00110;
   localparam logic [CTRL_W-1:0] ALU_OR   = 5'b00111;
   localparam logic [CTRL_W-1:0] ALU_XOR  = 5'b01000;
   localparam logic [CTRL_W-1:0] ALU_NOR  = 5'b01101;
   localparam logic [CTRL_W-1:0] ALU_SLT  = 5'b01110;

   localparam logic [5:0] OP_RTYPE    = 6'h00;
   localparam logic [5:0] OP_BEQ      = 6'h04;
   localparam logic [5:0] OP_BNE      = 6'h05;
   localparam logic [5:0] OP_ADDI     = 6'h08;
   localparam logic [5:0] OP_ADDIU    = 6'h09;
   localparam logic [5:0] OP_SLTI     = 6'h0A;
   localparam logic [5:0] OP_ANDI     = 6'h0C;
   localparam logic [5:0] OP_ORI      = 6'h0D;
   localparam logic [5:0] OP_XORI     = 6'h0E;
   localparam logic [5:0] OP_LUI      = 6'h0F;
   localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
   localparam logic [5:0] OP_LW       = 6'h23;
   localparam logic [5:0] OP_SW       = 6'h2B;

   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_SLLV = 6'h04;
   localparam logic [5:0] F_SRLV = 6'h06;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_XOR  = 6'h26;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2A;
   localparam logic [5:0] F_MUL  = 6'h02;

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational MIPS decode to ALU op code and operands
module alu_ctrl_decode
   import alu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [31:0]       instr_i,
   input  logic [DATA_W-1:0] rs_data_i,
   input  logic [DATA_W-1:0] rt_data_i,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [DATA_W-1:0] a_o,
   output logic [DATA_W-1:0] b_o,
   output logic [4:0]        write_reg_o,
   output logic              reg_write_o,
   output logic              illegal_o
);

   logic [5:0]        opcode, funct;
   logic [4:0]        rt, rd, shamt;
   logic [15:0]       imm;
   logic [DATA_W-1:0] imm_sext, imm_zext, imm_lui, shamt_a, shvar_a;
   logic [CTRL_W-1:0] ctrl;
   logic [DATA_W-1:0] a, b;
   logic [4:0]        wr;
   logic              rw, ill;
   // Register numbers arrive as data, so the rs field itself is not needed
   logic              unused_rs;

   assign opcode    = instr_i[31:26];
   assign rt        = instr_i[20:16];
   assign rd        = instr_i[15:11];
   assign shamt     = instr_i[10:6];
   assign funct     = instr_i[5:0];
   assign imm       = instr_i[15:0];
   assign unused_rs = ^instr_i[25:21];

   assign imm_sext = {{(DATA_W-16){imm[15]}}, imm};
   assign imm_zext = {{(DATA_W-16){1'b0}}, imm};
   assign imm_lui  = {imm, {(DATA_W-16){1'b0}}};
   // The ALU takes the shift amount from A[10:6]
   assign shamt_a  = DATA_W'({shamt, 6'b0});
   assign shvar_a  = DATA_W'({rs_data_i[4:0], 6'b0});

   always_comb begin
      ctrl = ALU_NONE;
      a    = rs_data_i;
      b    = rt_data_i;
      wr   = rt;
      rw   = 1'b0;
      ill  = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            wr = rd;
            rw = 1'b1;
            case (funct)
               F_ADD, F_ADDU: ctrl = ALU_ADD;
               F_SUB, F_SUBU: ctrl = ALU_SUB;
               F_AND:         ctrl = ALU_AND;
               F_OR:          ctrl = ALU_OR;
               F_XOR:         ctrl = ALU_XOR;
               F_NOR:         ctrl = ALU_NOR;
               F_SLT:         ctrl = ALU_SLT;
               F_SLL:  begin ctrl = ALU_SLL; a = shamt_a; end
               F_SRL:  begin ctrl = ALU_SRL; a = shamt_a; end
               F_SLLV: begin ctrl = ALU_SLL; a = shvar_a; end
               F_SRLV: begin ctrl = ALU_SRL; a = shvar_a; end
               default: ill = 1'b1;
            endcase
         end
         OP_SPECIAL2: begin
            if (funct == F_MUL) begin
               ctrl = ALU_MUL;
               wr   = rd;
               rw   = 1'b1;
            end else begin
               ill = 1'b1;
            end
         end
         OP_ADDI, OP_ADDIU, OP_LW: begin ctrl = ALU_ADD; b = imm_sext; rw = 1'b1; end
         OP_SLTI: begin ctrl = ALU_SLT; b = imm_sext; rw = 1'b1; end
         OP_ANDI: begin ctrl = ALU_AND; b = imm_zext; rw = 1'b1; end
         OP_ORI:  begin ctrl = ALU_OR;  b = imm_zext; rw = 1'b1; end
         OP_XORI: begin ctrl = ALU_XOR; b = imm_zext; rw = 1'b1; end
         OP_LUI:  begin ctrl = ALU_OR;  a = '0; b = imm_lui; rw = 1'b1; end
         OP_SW:   begin ctrl = ALU_ADD; b = imm_sext; end
         OP_BEQ, OP_BNE: begin ctrl = ALU_SUB; wr = 5'd0; end
         default: ill = 1'b1;
      endcase
      if (ill) begin
         ctrl = ALU_NONE;
         a    = '0;
         b    = '0;
         wr   = 5'd0;
         rw   = 1'b0;
      end
   end

   assign ctrl_o      = ctrl;
   assign a_o         = a;
   assign b_o         = b;
   assign write_reg_o = wr;
   assign reg_write_o = rw && (wr != 5'd0);
   assign illegal_o   = ill;

endmodule

// File: rtl/alu_ctrl_stage.sv
// rtl/alu_ctrl_stage.sv - registered decode-to-execute stage with stall/flush and illegal counter
module alu_ctrl_stage
   import alu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 8
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Valid_i,
   input  logic [31:0]       Instr_i,
   input  logic [DATA_W-1:0] RsData_i,
   input  logic [DATA_W-1:0] RtData_i,
   input  logic              Stall_i,
   input  logic              Flush_i,
   output logic [CTRL_W-1:0] ALUControl_o,
   output logic [DATA_W-1:0] A_o,
   output logic [DATA_W-1:0] B_o,
   output logic [4:0]        WriteReg_o,
   output logic              RegWrite_o,
   output logic              Valid_o,
   output logic              Illegal_o,
   output logic [CNT_W-1:0]  IllegalCount_o
);

   logic [CTRL_W-1:0] dec_ctrl, ctrl_q, ctrl_d;
   logic [DATA_W-1:0] dec_a, dec_b, a_q, a_d, b_q, b_d;
   logic [4:0]        dec_wr, wr_q, wr_d;
   logic              dec_rw, dec_ill, rw_q, rw_d, valid_q, valid_d, ill_q, ill_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   alu_ctrl_decode #(.DATA_W(DATA_W)) u_decode (
      .instr_i     (Instr_i),
      .rs_data_i   (RsData_i),
      .rt_data_i   (RtData_i),
      .ctrl_o      (dec_ctrl),
      .a_o         (dec_a),
      .b_o         (dec_b),
      .write_reg_o (dec_wr),
      .reg_write_o (dec_rw),
      .illegal_o   (dec_ill)
   );

   always_comb begin
      ctrl_d  = ctrl_q;
      a_d     = a_q;
      b_d     = b_q;
      wr_d    = wr_q;
      rw_d    = rw_q;
      valid_d = valid_q;
      ill_d   = ill_q;
      cnt_d   = cnt_q;
      if (Flush_i || (!Stall_i && !Valid_i)) begin
         ctrl_d  = ALU_NONE;
         a_d     = '0;
         b_d     = '0;
         wr_d    = 5'd0;
         rw_d    = 1'b0;
         valid_d = 1'b0;
         ill_d   = 1'b0;
      end else if (!Stall_i) begin
         ctrl_d  = dec_ctrl;
         a_d     = dec_a;
         b_d     = dec_b;
         wr_d    = dec_wr;
         rw_d    = dec_rw;
         valid_d = 1'b1;
         ill_d   = dec_ill;
         if (dec_ill && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         ctrl_q  <= ALU_NONE;
         a_q     <= '0;
         b_q     <= '0;
         wr_q    <= 5'd0;
         rw_q    <= 1'b0;
         valid_q <= 1'b0;
         ill_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         ctrl_q  <= ctrl_d;
         a_q     <= a_d;
         b_q     <= b_d;
         wr_q    <= wr_d;
         rw_q    <= rw_d;
         valid_q <= valid_d;
         ill_q   <= ill_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ALUControl_o   = ctrl_q;
   assign A_o            = a_q;
   assign B_o            = b_q;
   assign WriteReg_o     = wr_q;
   assign RegWrite_o     = rw_q;
   assign Valid_o        = valid_q;
   assign Illegal_o      = ill_q;
   assign IllegalCount_o = cnt_q;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// tb/tb_alu_ctrl_stage.sv - scoreboard bench for alu_ctrl_stage with directed vectors
module tb_alu_ctrl_stage;

   typedef struct packed {
      logic [4:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  wr;
      logic        rw;
      logic        v;
      logic        ill;
      logic [7:0]  cnt;
   } exp_t;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Valid_i, Stall_i, Flush_i;
   logic [31:0] Instr_i, RsData_i, RtData_i;
   logic [4:0]  ALUControl_o;
   logic [31:0] A_o, B_o;
   logic [4:0]  WriteReg_o;
   logic        RegWrite_o, Valid_o, Illegal_o;
   logic [7:0]  IllegalCount_o;

   exp_t        q[$];
   exp_t        last_e;
   logic [7:0]  mcnt;
   logic        rst_probe = 1'b0;
   logic        done = 1'b0;
   int          checks = 0;
   int          errors = 0;

   alu_ctrl_stage #(.DATA_W(32), .CNT_W(8)) dut (
      .Clk            (Clk),
      .Reset          (Reset),
      .Valid_i        (Valid_i),
      .Instr_i        (Instr_i),
      .RsData_i       (RsData_i),
      .RtData_i       (RtData_i),
      .Stall_i        (Stall_i),
      .Flush_i        (Flush_i),
      .ALUControl_o   (ALUControl_o),
      .A_o            (A_o),
      .B_o            (B_o),
      .WriteReg_o     (WriteReg_o),
      .RegWrite_o     (RegWrite_o),
      .Valid_o        (Valid_o),
      .Illegal_o      (Illegal_o),
      .IllegalCount_o (IllegalCount_o)
   );

   always #5 Clk = ~Clk;

   task automatic compare(input string name, input exp_t e);
      exp_t act;
      act.ctrl = ALUControl_o; act.a = A_o; act.b = B_o; act.wr = WriteReg_o;
      act.rw = RegWrite_o; act.v = Valid_o; act.ill = Illegal_o; act.cnt = IllegalCount_o;
      checks++;
      if (act !== e) begin
         errors++;
         $display("FAIL %s: got ctrl=%h a=%h b=%h wr=%0d rw=%b v=%b ill=%b cnt=%0d, want ctrl=%h a=%h b=%h wr=%0d rw=%b v=%b ill=%b cnt=%0d",
                  name, act.ctrl, act.a, act.b, act.wr, act.rw, act.v, act.ill, act.cnt,
                  e.ctrl, e.a, e.b, e.wr, e.rw, e.v, e.ill, e.cnt);
      end
   endtask

   // Monitor: async-reset probe, per-cycle scoreboard pop, end-of-run drain check
   always @(negedge Clk or posedge rst_probe) begin
      if (rst_probe) begin
         compare("async_reset", '0);
      end else begin
         if (!Reset && q.size() > 0) compare("scoreboard", q.pop_front());
         if (done) begin
            checks++;
            if (q.size() != 0) begin
               errors++;
               $display("FAIL drain: %0d entries left, want 0", q.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] rs,
                        input logic [31:0] rt, input logic st, input logic fl);
      @(negedge Clk);
      #1;
      Valid_i = v; Instr_i = instr; RsData_i = rs; RtData_i = rt; Stall_i = st; Flush_i = fl;
   endtask

   task automatic load(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [4:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wr, input logic rw, input logic ill);
      exp_t e;
      drive(1'b1, instr, rs, rt, 1'b0, 1'b0);
      if (ill && mcnt != 8'hFF) mcnt = mcnt + 8'd1;
      e.ctrl = ctrl; e.a = a; e.b = b; e.wr = wr; e.rw = rw; e.v = 1'b1; e.ill = ill; e.cnt = mcnt;
      q.push_back(e);
      last_e = e;
   endtask

   task automatic illegal(input logic [31:0] instr);
      load(instr, 32'h1111_2222, 32'h3333_4444, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
   endtask

   task automatic bubble_op(input logic v, input logic [31:0] instr, input logic st, input logic fl);
      exp_t e;
      drive(v, instr, 32'hAAAA_5555, 32'h5555_AAAA, st, fl);
      e = '0;
      e.cnt = mcnt;
      q.push_back(e);
      last_e = e;
   endtask

   task automatic stall(input logic [31:0] instr);
      drive(1'b1, instr, 32'h0BAD_F00D, 32'hDEAD_BEEF, 1'b1, 1'b0);
      q.push_back(last_e);
   endtask

   initial begin
      Reset = 1'b1; Valid_i = 1'b0; Instr_i = '0; RsData_i = '0; RtData_i = '0;
      Stall_i = 1'b0; Flush_i = 1'b0; mcnt = 8'd0; last_e = '0;
      #3 rst_probe = 1'b1;
      #1 rst_probe = 1'b0;
      @(negedge Clk); #1 Reset = 1'b0;

      bubble_op(1'b0, 32'h0022_1820, 1'b0, 1'b0);
      // add $3,$1,$2
      load(32'h0022_1820, 32'd5, 32'd7, 5'b00001, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
      // sll $4,$2,3
      load(32'h0002_20C0, 32'h1234_5678, 32'h0000_000F, 5'b00100, 32'h0000_00C0, 32'h0000_000F, 5'd4, 1'b1, 1'b0);
      // nop
      load(32'h0000_0000, 32'd0, 32'h55, 5'b00100, 32'd0, 32'h55, 5'd0, 1'b0, 1'b0);
      // addi $5,$1,-1 and andi $5,$1,0xFFFF
      load(32'h2025_FFFF, 32'd10, 32'd99, 5'b00001, 32'd10, 32'hFFFF_FFFF, 5'd5, 1'b1, 1'b0);
      load(32'h3025_FFFF, 32'hF0F0_F0F0, 32'd99, 5'b00110, 32'hF0F0_F0F0, 32'h0000_FFFF, 5'd5, 1'b1, 1'b0);

      // Reset mid-stream with live add on the inputs
      load(32'h0022_1820, 32'd5, 32'd7, 5'b00001, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
      @(negedge Clk); #1 Reset = 1'b1;
      #1 rst_probe = 1'b1;
      #1 rst_probe = 1'b0;
      @(negedge Clk); #1 Reset = 1'b0;
      mcnt = 8'd0; last_e = '0;
      bubble_op(1'b0, 32'h0022_1820, 1'b0, 1'b0);

      // opcode 0x3F
      illegal(32'hFC00_0000);

      // Stall holds, then stall+flush gives a bubble
      load(32'h0022_1820, 32'd5, 32'd7, 5'b00001, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
      stall(32'h3C06_1234);
      stall(32'hFC00_0000);
      stall(32'h0022_1822);
      bubble_op(1'b1, 32'h0022_1820, 1'b1, 1'b1);

      // lui, sw, sllv, mul, sub, add to $0
      load(32'h3C06_1234, 32'h7777_7777, 32'd1, 5'b00111, 32'd0, 32'h1234_0000, 5'd6, 1'b1, 1'b0);
      load(32'hAC22_0004, 32'h0000_1000, 32'd8, 5'b00001, 32'h0000_1000, 32'd4, 5'd2, 1'b0, 1'b0);
      load(32'h00A4_1804, 32'hFFFF_FFE7, 32'h8000_0001, 5'b00100, 32'h0000_01C0, 32'h8000_0001, 5'd3, 1'b1, 1'b0);
      load(32'h7022_1802, 32'd6, 32'd9, 5'b00011, 32'd6, 32'd9, 5'd3, 1'b1, 1'b0);
      load(32'h0022_1822, 32'd20, 32'd8, 5'b00010, 32'd20, 32'd8, 5'd3, 1'b1, 1'b0);
      load(32'h0022_0020, 32'd1, 32'd2, 5'b00001, 32'd1, 32'd2, 5'd0, 1'b0, 1'b0);

      // illegal funct, then flushed illegal must not count
      illegal(32'h0022_1801);
      bubble_op(1'b1, 32'hFC00_0000, 1'b0, 1'b1);
      bubble_op(1'b0, 32'hFC00_0000, 1'b0, 1'b0);

      for (int i = 0; i < 300; i++) illegal(32'hFC00_0000 | i);
      stall(32'hFC00_0000);
      load(32'h0022_1820, 32'd5, 32'd7, 5'b00001, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);

      @(negedge Clk); #1;
      Valid_i = 1'b0;
      done = 1'b1;
   end

endmodule
